sha3_axis_absorb: RTL and testbench

- Parametrised AXI-Stream input stage for the SHA3 core. Packs WIDTH-bit stream beats into rate-sized Keccak blocks for the mode selected by s_tuser (224/256/384/512).
- Applies SHA3 padding (0x06 … 0x80) at end of message.
- Hands each block, with its mode and a last-block flag, to the permutation over a valid/ready interface.
- Replaces the fixed 16-bit input path; adds byte-granular final beats and generated padding blocks.

---
 rtl/sha3_axis_absorb.sv | 240 ++++++++++++++++++++++++
 tb/tb_sha3_axis_absorb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_axis_absorb.sv
// sha3_axis_absorb
// ----------------
// AXI-Stream absorb stage for the SHA3 core. WIDTH-bit little-endian beats
// are packed into a single rate-sized Keccak block buffer. SHA3 padding
// (0x06 ... 0x80) is applied at end of message, and each finished block is
// offered to the permutation over a valid/ready handshake.
//
// Ports
//   ACLK, ARESETn      clock, asynchronous active-low reset
//   s_tdata  [WIDTH]   message bytes, byte 0 in [7:0]
//   s_tkeep  [WIDTH/8] byte enables, only looked at on the tlast beat
//   s_tuser  [2]       mode 0..3 = SHA3-224/256/384/512, sampled on first beat
//   s_tvalid/s_tready  input beat handshake
//   s_tlast            final beat of the message
//   blk_data [1600]    block, rate bytes low, capacity bits zero
//   blk_mode [2]       mode of the message owning the block
//   blk_last           block is the final padded block of its message
//   blk_valid/blk_ready block handshake
//   err_keep           one-cycle pulse on non-contiguous tkeep with tlast
module sha3_axis_absorb #(
    parameter int WIDTH = 16
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic [WIDTH-1:0]   s_tdata,
    input  logic [WIDTH/8-1:0] s_tkeep,
    input  logic [1:0]         s_tuser,
    input  logic               s_tvalid,
    input  logic               s_tlast,
    output logic               s_tready,
    output logic [1599:0]      blk_data,
    output logic [1:0]         blk_mode,
    output logic               blk_last,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic               err_keep
);

    localparam int NB = WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_OUT  = 2'd2,
        ST_PAD  = 2'd3
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [7:0]    byte_cnt_r, byte_cnt_nxt_s;
    logic [1599:0] blk_data_r, blk_data_nxt_s;
    logic [1:0]    blk_mode_r, blk_mode_nxt_s;
    logic          blk_last_r, blk_last_nxt_s;
    logic          blk_valid_r, blk_valid_nxt_s;
    logic          s_tready_r, s_tready_nxt_s;
    logic          err_keep_r, err_keep_nxt_s;
    logic          pad_pend_r, pad_pend_nxt_s;

    logic [1:0]       mode_sel_s;
    logic [7:0]       rate_s;
    logic [3:0]       keep_cnt_s;
    logic             keep_run_s;
    logic             keep_err_s;
    logic [3:0]       beat_bytes_s;
    logic [WIDTH-1:0] beat_data_s;
    logic [7:0]       fill_cnt_s;
    logic             accept_s;

    // Rate in bytes for each SHA3 output length.
    function automatic logic [7:0] rate_bytes(input logic [1:0] mode);
        logic [7:0] r;
        case (mode)
            2'd0:    r = 8'd144;
            2'd1:    r = 8'd136;
            2'd2:    r = 8'd104;
            2'd3:    r = 8'd72;
            default: r = 8'd136;
        endcase
        return r;
    endfunction

    // One byte value placed at byte position pos of a block-width vector.
    function automatic logic [1599:0] byte_at(input logic [7:0] val, input logic [7:0] pos);
        return 1600'(val) << {pos, 3'b000};
    endfunction

    // Count low-justified kept bytes on the beat; flag any set bit after a gap.
    always_comb begin
        keep_cnt_s = 4'd0;
        keep_run_s = 1'b1;
        keep_err_s = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (s_tkeep[b]) begin
                if (keep_run_s) begin
                    keep_cnt_s = keep_cnt_s + 4'd1;
                end else begin
                    keep_err_s = 1'b1;
                end
            end else begin
                keep_run_s = 1'b0;
            end
        end
    end

    // Mask the beat down to the bytes that actually count.
    always_comb begin
        beat_bytes_s = s_tlast ? keep_cnt_s : 4'(NB);
        beat_data_s  = '0;
        for (int b = 0; b < NB; b++) begin
            if (4'(b) < beat_bytes_s) begin
                beat_data_s[b*8 +: 8] = s_tdata[b*8 +: 8];
            end else begin
                beat_data_s[b*8 +: 8] = 8'h00;
            end
        end
    end

    // In IDLE the mode register is stale, so the incoming s_tuser decides R.
    assign mode_sel_s = (state_r == ST_IDLE) ? s_tuser : blk_mode_r;
    assign rate_s     = rate_bytes(mode_sel_s);
    assign fill_cnt_s = byte_cnt_r + {4'd0, beat_bytes_s};
    assign accept_s   = s_tvalid & s_tready_r &
                        ((state_r == ST_IDLE) | (state_r == ST_FILL));

    // Next-state and next-output logic.
    always_comb begin
        state_nxt_s     = state_r;
        byte_cnt_nxt_s  = byte_cnt_r;
        blk_data_nxt_s  = blk_data_r;
        blk_mode_nxt_s  = blk_mode_r;
        blk_last_nxt_s  = blk_last_r;
        blk_valid_nxt_s = blk_valid_r;
        pad_pend_nxt_s  = pad_pend_r;
        err_keep_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_FILL: begin
                if (accept_s) begin
                    if (state_r == ST_IDLE) begin
                        blk_mode_nxt_s = s_tuser;
                    end else begin
                        blk_mode_nxt_s = blk_mode_r;
                    end
                    err_keep_nxt_s = s_tlast & keep_err_s;
                    // Bytes above byte_cnt are always zero, so OR-in is a write.
                    blk_data_nxt_s = blk_data_r | (1600'(beat_data_s) << {byte_cnt_r, 3'b000});
                    byte_cnt_nxt_s = fill_cnt_s;
                    if (s_tlast) begin
                        if (fill_cnt_s < rate_s) begin
                            // p == R-1 lands both pad bytes on one byte: 0x86.
                            blk_data_nxt_s = blk_data_nxt_s | byte_at(8'h06, fill_cnt_s)
                                                            | byte_at(8'h80, rate_s - 8'd1);
                            blk_last_nxt_s = 1'b1;
                        end else begin
                            // Message exactly fills the block: pad block follows.
                            blk_last_nxt_s = 1'b0;
                            pad_pend_nxt_s = 1'b1;
                        end
                        blk_valid_nxt_s = 1'b1;
                        state_nxt_s     = ST_OUT;
                    end else if (fill_cnt_s == rate_s) begin
                        blk_last_nxt_s  = 1'b0;
                        blk_valid_nxt_s = 1'b1;
                        state_nxt_s     = ST_OUT;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_OUT: begin
                if (blk_ready) begin
                    blk_data_nxt_s  = '0;
                    byte_cnt_nxt_s  = 8'd0;
                    blk_valid_nxt_s = 1'b0;
                    blk_last_nxt_s  = 1'b0;
                    if (pad_pend_r) begin
                        pad_pend_nxt_s = 1'b0;
                        state_nxt_s    = ST_PAD;
                    end else if (blk_last_r) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            ST_PAD: begin
                blk_data_nxt_s  = byte_at(8'h06, 8'd0) | byte_at(8'h80, rate_s - 8'd1);
                blk_last_nxt_s  = 1'b1;
                blk_valid_nxt_s = 1'b1;
                state_nxt_s     = ST_OUT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        s_tready_nxt_s = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_FILL);
    end

    // FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Block buffer, counters and registered outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            byte_cnt_r  <= 8'd0;
            blk_data_r  <= '0;
            blk_mode_r  <= 2'd0;
            blk_last_r  <= 1'b0;
            blk_valid_r <= 1'b0;
            s_tready_r  <= 1'b0;
            err_keep_r  <= 1'b0;
            pad_pend_r  <= 1'b0;
        end else begin
            byte_cnt_r  <= byte_cnt_nxt_s;
            blk_data_r  <= blk_data_nxt_s;
            blk_mode_r  <= blk_mode_nxt_s;
            blk_last_r  <= blk_last_nxt_s;
            blk_valid_r <= blk_valid_nxt_s;
            s_tready_r  <= s_tready_nxt_s;
            err_keep_r  <= err_keep_nxt_s;
            pad_pend_r  <= pad_pend_nxt_s;
        end
    end

    assign s_tready  = s_tready_r;
    assign blk_data  = blk_data_r;
    assign blk_mode  = blk_mode_r;
    assign blk_last  = blk_last_r;
    assign blk_valid = blk_valid_r;
    assign err_keep  = err_keep_r;

endmodule

// File: tb/tb_sha3_axis_absorb.sv
// Directed bench for sha3_axis_absorb: a 16-bit instance carries most
// vectors, a 32-bit instance covers the 0x86 single-byte padding case.
module tb_sha3_axis_absorb;

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;
    logic ARESETn;

    // 16-bit instance
    logic [15:0]   s_tdata;
    logic [1:0]    s_tkeep;
    logic [1:0]    s_tuser;
    logic          s_tvalid, s_tlast, s_tready;
    logic [1599:0] blk_data;
    logic [1:0]    blk_mode;
    logic          blk_last, blk_valid, blk_ready, err_keep;

    // 32-bit instance
    logic [31:0]   w_tdata;
    logic [3:0]    w_tkeep;
    logic [1:0]    w_tuser;
    logic          w_tvalid, w_tlast, w_tready;
    logic [1599:0] w_blk_data;
    logic [1:0]    w_blk_mode;
    logic          w_blk_last, w_blk_valid, w_blk_ready, w_err_keep;

    sha3_axis_absorb #(.WIDTH(16)) u_dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
        .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .blk_data(blk_data), .blk_mode(blk_mode), .blk_last(blk_last),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .err_keep(err_keep)
    );

    sha3_axis_absorb #(.WIDTH(32)) u_dut_w (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_tdata(w_tdata), .s_tkeep(w_tkeep), .s_tuser(w_tuser),
        .s_tvalid(w_tvalid), .s_tlast(w_tlast), .s_tready(w_tready),
        .blk_data(w_blk_data), .blk_mode(w_blk_mode), .blk_last(w_blk_last),
        .blk_valid(w_blk_valid), .blk_ready(w_blk_ready), .err_keep(w_err_keep)
    );

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [7:0]    msg [0:511];
    logic [1599:0] exp_blk [0:7];
    logic          exp_last [0:7];
    logic          exp_rdy [0:7];
    int            exp_n;
    int            exp_mode;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_block(input string tag, input logic [1599:0] got, input logic [1599:0] exp);
        for (int l = 0; l < 25; l++) begin
            check($sformatf("%s lane%0d", tag, l), got[l*64 +: 64], exp[l*64 +: 64]);
        end
    endtask

    function automatic int rate_of(input int m);
        case (m)
            0:       return 144;
            1:       return 136;
            2:       return 104;
            default: return 72;
        endcase
    endfunction

    // Reference blocks from the message byte array.
    task automatic build_exp(input int len, input int mode);
        int r, pos, rem;
        logic [1599:0] tmp;
        r = rate_of(mode);
        pos = 0;
        exp_n = 0;
        exp_mode = mode;
        forever begin
            rem = len - pos;
            tmp = '0;
            if (rem >= r) begin
                for (int i = 0; i < r; i++) tmp[i*8 +: 8] = msg[pos+i];
                exp_blk[exp_n]  = tmp;
                exp_last[exp_n] = 1'b0;
                exp_rdy[exp_n]  = (rem != r);
                exp_n++;
                pos += r;
            end else begin
                for (int i = 0; i < rem; i++) tmp[i*8 +: 8] = msg[pos+i];
                tmp[rem*8 +: 8]   = tmp[rem*8 +: 8] | 8'h06;
                tmp[(r-1)*8 +: 8] = tmp[(r-1)*8 +: 8] | 8'h80;
                exp_blk[exp_n]  = tmp;
                exp_last[exp_n] = 1'b1;
                exp_rdy[exp_n]  = 1'b1;
                exp_n++;
                break;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic l, input logic [1:0] u);
        int waited;
        logic got;
        waited = 0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        forever begin
            got = s_tready;
            @(posedge ACLK);
            @(negedge ACLK);
            if (got) break;
            waited++;
            if (waited > 2000) begin
                check("tready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_beat_w(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] u);
        int waited;
        logic got;
        waited = 0;
        w_tdata = d; w_tkeep = k; w_tlast = l; w_tuser = u; w_tvalid = 1'b1;
        forever begin
            got = w_tready;
            @(posedge ACLK);
            @(negedge ACLK);
            if (got) break;
            waited++;
            if (waited > 2000) begin
                check("w_tready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        w_tvalid = 1'b0;
        w_tlast  = 1'b0;
    endtask

    task automatic send_msg(input int len, input int mode, input bit toggle);
        int nb, rem;
        logic [1:0] keep, user;
        logic last;
        nb = (len == 0) ? 1 : (len + 1) / 2;
        for (int k = 0; k < nb; k++) begin
            last = (k == nb - 1);
            rem  = len - 2 * k;
            keep = !last ? 2'b11 : (rem >= 2) ? 2'b11 : (rem == 1) ? 2'b01 : 2'b00;
            user = 2'(mode);
            if (toggle && k >= 5) user = ~user;
            send_beat({msg[2*k+1], msg[2*k]}, keep, last, user);
        end
    endtask

    task automatic collect(input int idx, input int hold, input string tag);
        int waited;
        logic [1599:0] snap;
        waited = 0;
        while (blk_valid !== 1'b1) begin
            @(negedge ACLK);
            waited++;
            if (waited > 3000) begin
                check({tag, "_valid_timeout"}, 64'd0, 64'd1);
                return;
            end
        end
        check_block(tag, blk_data, exp_blk[idx]);
        check({tag, "_last"}, 64'(blk_last), 64'(exp_last[idx]));
        check({tag, "_mode"}, 64'(blk_mode), 64'(exp_mode));
        snap = blk_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge ACLK);
            check({tag, "_held"}, 64'(blk_valid === 1'b1 && blk_data === snap), 64'd1);
            check({tag, "_tready_held"}, 64'(s_tready), 64'd0);
        end
        blk_ready = 1'b1;
        @(negedge ACLK);
        blk_ready = 1'b0;
        check({tag, "_tready_after"}, 64'(s_tready), 64'(exp_rdy[idx]));
    endtask

    task automatic run_msg(input int len, input int mode, input int hold, input bit toggle, input string tag);
        exp_mode = mode;
        fork
            send_msg(len, mode, toggle);
            begin
                for (int n = 0; n < exp_n; n++) collect(n, hold, $sformatf("%s_b%0d", tag, n));
            end
        join
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tready"}, 64'(s_tready), 64'd0);
        check({tag, "_valid"}, 64'(blk_valid), 64'd0);
        check({tag, "_last"}, 64'(blk_last), 64'd0);
        check({tag, "_mode"}, 64'(blk_mode), 64'd0);
        check({tag, "_err"}, 64'(err_keep), 64'd0);
        check_block({tag, "_data"}, blk_data, 1600'd0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int wait_w;
        logic [1599:0] tmp;
        ARESETn = 1'b1;
        s_tdata = 16'd0; s_tkeep = 2'b00; s_tuser = 2'd0; s_tvalid = 1'b0; s_tlast = 1'b0;
        w_tdata = 32'd0; w_tkeep = 4'd0; w_tuser = 2'd0; w_tvalid = 1'b0; w_tlast = 1'b0;
        blk_ready = 1'b0; w_blk_ready = 1'b0;
        for (int i = 0; i < 512; i++) msg[i] = 8'h00;
        #2 ARESETn = 1'b0;
        #1 check_reset_outputs("rst");
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("idle_tready", 64'(s_tready), 64'd1);

        // Empty message, mode 1
        tmp = '0; tmp[7:0] = 8'h06; tmp[135*8 +: 8] = 8'h80;
        exp_blk[0] = tmp; exp_last[0] = 1'b1; exp_rdy[0] = 1'b1; exp_n = 1;
        run_msg(0, 1, 0, 1'b0, "empty");

        // "abc", mode 0
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg[3] = 8'h00;
        tmp = '0; tmp[31:0] = 32'h06636261; tmp[143*8 +: 8] = 8'h80;
        exp_blk[0] = tmp; exp_last[0] = 1'b1; exp_rdy[0] = 1'b1; exp_n = 1;
        run_msg(3, 0, 0, 1'b0, "abc");

        // 72-byte message, mode 3: full block then pad-only block
        for (int i = 0; i < 512; i++) msg[i] = 8'(i * 7 + 3);
        build_exp(72, 3);
        run_msg(72, 3, 0, 1'b0, "m72");

        // 32-bit instance, 135 bytes mode 1 -> byte 135 = 0x86
        for (int k = 0; k < 33; k++) begin
            send_beat_w({msg[4*k+3], msg[4*k+2], msg[4*k+1], msg[4*k]}, 4'b1111, 1'b0, 2'd1);
        end
        send_beat_w({8'hEE, msg[134], msg[133], msg[132]}, 4'b0111, 1'b1, 2'd1);
        tmp = '0;
        for (int i = 0; i < 135; i++) tmp[i*8 +: 8] = msg[i];
        tmp[135*8 +: 8] = 8'h86;
        wait_w = 0;
        while (w_blk_valid !== 1'b1 && wait_w < 100) begin
            @(negedge ACLK);
            wait_w++;
        end
        check("w135_valid", 64'(w_blk_valid), 64'd1);
        check_block("w135", w_blk_data, tmp);
        check("w135_last", 64'(w_blk_last), 64'd1);
        check("w135_mode", 64'(w_blk_mode), 64'd1);
        check("w135_tready_held", 64'(w_tready), 64'd0);
        w_blk_ready = 1'b1;
        @(negedge ACLK);
        w_blk_ready = 1'b0;
        check("w135_tready_after", 64'(w_tready), 64'd1);

        // 300 bytes mode 2, consumer stalls 10 cycles, s_tuser toggles mid-message
        build_exp(300, 2);
        run_msg(300, 2, 10, 1'b1, "m300");

        // Non-contiguous keep on a lone tlast beat: counts zero bytes
        send_beat(16'hABCD, 2'b10, 1'b1, 2'd0);
        check("errkeep_pulse", 64'(err_keep), 64'd1);
        check("errkeep_latency", 64'(blk_valid), 64'd1);
        @(negedge ACLK);
        check("errkeep_clear", 64'(err_keep), 64'd0);
        tmp = '0; tmp[7:0] = 8'h06; tmp[143*8 +: 8] = 8'h80;
        exp_blk[0] = tmp; exp_last[0] = 1'b1; exp_rdy[0] = 1'b1; exp_n = 1; exp_mode = 0;
        collect(0, 0, "errkeep");

        // Reset after 20 beats of a mode-1 message
        for (int k = 0; k < 20; k++) send_beat({msg[2*k+1], msg[2*k]}, 2'b11, 1'b0, 2'd1);
        check("mid_no_block", 64'(blk_valid), 64'd0);
        ARESETn = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("postrst_valid", 64'(blk_valid), 64'd0);
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg[3] = 8'h00;
        tmp = '0; tmp[31:0] = 32'h06636261; tmp[103*8 +: 8] = 8'h80;
        exp_blk[0] = tmp; exp_last[0] = 1'b1; exp_rdy[0] = 1'b1; exp_n = 1;
        run_msg(3, 2, 0, 1'b0, "abc2");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
